// File: rtl/hack_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hack_ram_pkg
//  Purpose  : Shared constants, types and helpers for the Hack data RAM.
//             32K x 16 storage split into 8 banks of 4K words each.
//  Contents : DATA_W / ADDR_W / BANK_AW / NUM_BANKS constants,
//             word_t, addr_t, bank_sel_t, bank_off_t typedefs,
//             state_e controller states, address split helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package hack_ram_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 15;
  localparam int BANK_AW   = 12;
  localparam int SEL_W     = ADDR_W - BANK_AW;
  localparam int NUM_BANKS = 2 ** SEL_W;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [SEL_W-1:0]   bank_sel_t;
  typedef logic [BANK_AW-1:0] bank_off_t;

  // ST_RESET : waiting for the first edge with reset released
  // ST_CLEAR : zero-fill sweep in progress (only reachable with the clear build)
  // ST_RUN   : memory usable
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  function automatic bank_sel_t bank_of(input addr_t a);
    return a[ADDR_W-1:BANK_AW];
  endfunction

  function automatic bank_off_t offset_of(input addr_t a);
    return a[BANK_AW-1:0];
  endfunction

endpackage : hack_ram_pkg
`default_nettype wire

// File: rtl/hack_ram_bank.sv
`default_nettype none
// ============================================================================
//  Module   : hack_ram_bank
//  Purpose  : One 2**BANK_AW x DATA_W storage bank with a single synchronous
//             write port and a combinational read port.
//  Ports    : clk      - system clock
//             we_i     - write enable (writes wdata_i to waddr_i at rising edge)
//             waddr_i  - write offset
//             wdata_i  - write data
//             raddr_i  - read offset
//             rdata_o  - read data, mem[raddr_i] (old value during a write)
//  Revision : 1.0 - initial release
// ============================================================================
module hack_ram_bank
  import hack_ram_pkg::*;
(
  input  logic      clk,
  input  logic      we_i,
  input  bank_off_t waddr_i,
  input  word_t     wdata_i,
  input  bank_off_t raddr_i,
  output word_t     rdata_o
);

  // Contents are intentionally not reset; they are undefined after power-up.
  word_t mem_q [2**BANK_AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-first behaviour: no bypass of the write data onto the read path.
  assign rdata_o = mem_q[raddr_i];

endmodule : hack_ram_bank
`default_nettype wire

// File: rtl/hack_ram.sv
`default_nettype none
// ============================================================================
//  Module   : hack_ram
//  Purpose  : Hack computer data memory, 32K x 16, single-cycle synchronous
//             write and combinational read, built from NUM_BANKS banks.
//  Ports    : clk     - system clock
//             rst_n   - synchronous active-low reset
//             in      - write data
//             load    - write enable
//             address - word address (read and write)
//             out     - M[address] while ready, else 0
//             ready   - 1 when the memory is usable
//  Config   : HACK_RAM_CLEAR_EN - when defined, a zero-fill sweep over every
//             bank offset runs after reset release before ready rises.
//  Revision : 1.0 - initial release
// ============================================================================
module hack_ram
  import hack_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out,
  output logic              ready
);

`ifdef HACK_RAM_CLEAR_EN
  localparam state_e c_RST_STATE = ST_CLEAR;
`else
  localparam state_e c_RST_STATE = ST_RESET;
`endif

  state_e               state_q, state_d;
  bank_sel_t            w_sel;
  bank_off_t            w_off;
  logic [NUM_BANKS-1:0] w_bank_we;
  bank_off_t            w_waddr;
  word_t                w_wdata;
  word_t                w_rdata [NUM_BANKS];

  assign w_sel = bank_of(address);
  assign w_off = offset_of(address);

`ifdef HACK_RAM_CLEAR_EN
  bank_off_t clr_cnt_q, clr_cnt_d;

  // Sweep counter restarts from offset 0 whenever reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= c_RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
`ifdef HACK_RAM_CLEAR_EN
      // The edge that writes the last offset also raises ready.
      ST_CLEAR: if (clr_cnt_q == '1) state_d = ST_RUN;
`endif
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = c_RST_STATE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: write-enable fan-out, write mux, ready
  // ---------------------------------------------------------------------------
  always_comb begin
    w_bank_we = '0;
    w_waddr   = w_off;
    w_wdata   = in;
    ready     = (state_q == ST_RUN);
    // rst_n gates every write so a write at the reset edge is dropped.
    if (rst_n) begin
      case (state_q)
        ST_RUN: begin
          if (load) begin
            w_bank_we[w_sel] = 1'b1;
          end
        end
`ifdef HACK_RAM_CLEAR_EN
        ST_CLEAR: begin
          w_bank_we = '1;
          w_waddr   = clr_cnt_q;
          w_wdata   = '0;
        end
`endif
        default: w_bank_we = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Banks
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    hack_ram_bank u_bank (
      .clk     (clk),
      .we_i    (w_bank_we[b]),
      .waddr_i (w_waddr),
      .wdata_i (w_wdata),
      .raddr_i (w_off),
      .rdata_o (w_rdata[b])
    );
  end

  // Read mux; output held at zero until the memory is usable.
  assign out = ready ? w_rdata[w_sel] : '0;

endmodule : hack_ram
`default_nettype wire

// File: tb/tb_hack_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hack_ram
//  Purpose  : Self-checking bench for hack_ram (default build, clear sweep
//             disabled). Reference memory model plus an expected-value queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hack_ram;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        load;
  logic [14:0] address;
  logic [15:0] dout;
  logic        ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model [int];
  logic [15:0] exp_q [$];
  logic [14:0] rnd_addr [$];

  hack_ram dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (din),
    .load    (load),
    .address (address),
    .out     (dout),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%04h want 0x%04h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [14:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    din     = d;
    load    = 1'b1;
    @(posedge clk);
    model[int'(a)] = d;
    #1;
    load = 1'b0;
  endtask

  // Expected value is pushed from the model when the read is issued and
  // popped when the DUT output is sampled.
  task automatic do_read(input string tag, input logic [14:0] a);
    @(negedge clk);
    address = a;
    exp_q.push_back(model[int'(a)]);
    #1;
    check(tag, dout, exp_q.pop_front());
  endtask

  initial begin
    rst_n   = 1'b0;
    din     = 16'h0;
    load    = 1'b0;
    address = 15'h0;

    // Reset for two edges
    @(posedge clk); #1;
    check("reset_ready_e1", {15'b0, ready}, 16'h0);
    check("reset_out_e1", dout, 16'h0);
    @(posedge clk); #1;
    check("reset_ready_e2", {15'b0, ready}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_release_edge", {15'b0, ready}, 16'h0);
    @(posedge clk); #1;
    check("ready_after_release", {15'b0, ready}, 16'h1);

    // Write / read with read-during-write ordering
    do_write(15'h0000, 16'h1111);
    @(negedge clk);
    address = 15'h0000;
    din     = 16'h1234;
    load    = 1'b1;
    #1;
    check("raw_old_before_edge", dout, 16'h1111);
    @(posedge clk);
    model[0] = 16'h1234;
    #1;
    load = 1'b0;
    check("raw_new_after_edge", dout, 16'h1234);
    do_read("read_0000", 15'h0000);

    // Bank boundaries
    do_write(15'h0FFE, 16'h0123);
    do_write(15'h0FFF, 16'hAAAA);
    do_write(15'h1000, 16'h5555);
    do_write(15'h7FFF, 16'hBEEF);
    do_read("read_0FFF", 15'h0FFF);
    do_read("read_1000", 15'h1000);
    do_read("read_7FFF", 15'h7FFF);
    do_read("neighbour_0FFE", 15'h0FFE);
    do_read("read_0000_again", 15'h0000);

    // load=0 leaves memory unchanged
    do_write(15'h0003, 16'h00C3);
    @(negedge clk);
    address = 15'h0003;
    din     = 16'hFFFF;
    load    = 1'b0;
    @(posedge clk);
    do_read("load0_protect_0003", 15'h0003);

    // Reset blocks a concurrent write
    do_write(15'h0010, 16'h0010);
    @(negedge clk);
    rst_n   = 1'b0;
    load    = 1'b1;
    address = 15'h0010;
    din     = 16'h0777;
    @(posedge clk); #1;
    check("rst_ready_low", {15'b0, ready}, 16'h0);
    check("rst_out_zero", dout, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b0;
    @(posedge clk); #1;
    check("rst_ready_back", {15'b0, ready}, 16'h1);
    do_read("rst_dropped_write_0010", 15'h0010);

    // Random writes across all banks, then read back in reverse order
    for (int i = 0; i < 24; i++) begin
      logic [14:0] a;
      logic [15:0] d;
      a = 15'($urandom_range(0, 32767));
      d = 16'($urandom);
      rnd_addr.push_back(a);
      do_write(a, d);
    end
    for (int i = 23; i >= 0; i--) begin
      do_read($sformatf("rand_%0d_addr_%04h", i, rnd_addr[i]), rnd_addr[i]);
    end

    // Boundary words again (may have been overwritten; model tracks that)
    do_read("final_7FFF", 15'h7FFF);
    do_read("final_1000", 15'h1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hack_ram
`default_nettype wire
